prog_loader: RTL and testbench
==============================

# prog_loader

Program loader sitting between an external word stream and the microprocessor's instruction ROM. It accepts instruction words over a valid/ready handshake and writes them into consecutive ROM addresses from 0. It zero-fills every remaining location, then releases the processor from reset. It is the write side of program memory: it fills the ROM that the processor core later fetches from.

## Interface
- `IW`, 12, instruction word width in bits
- `ROM_addressBits`, 6, ROM address width; ROM depth is 2^ROM_addressBits words

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  source presents a word
- `in_data`  in  IW  instruction word
- `in_last`  in  1  marks the final word of the program; qualified by `in_valid`
- `in_ready`  out  1  loader accepts a word this cycle
- `reload`  in  1  restart loading; honoured only in RUN or ERR
- `rom_we`  out  1  ROM write enable, registered
- `rom_addr`  out  ROM_addressBits  ROM write address, registered
- `rom_wdata`  out  IW  ROM write data, registered
- `cpu_rst_n`  out  1  active-low reset to the processor core, registered
- `done`  out  1  high while in RUN
- `error`  out  1  high while in ERR (program overflow)
- `words_loaded`  out  ROM_addressBits+1  number of stream words accepted in the current load

## Operation
- States:
  - LOAD: accept stream words.
  - FILL: zero-fill the unused tail of the ROM.
  - RUN: program loaded, processor released.
  - ERR: overflow.
- Reset state is LOAD.
- Handshake: a word transfers on a rising edge where `in_valid && in_ready`. `in_ready` equals (state == LOAD) and is combinational from the state only; it does not depend on `in_valid`.
- Write address counter `wa`: reset to 0, increments by 1 per transfer and per FILL write.
- LOAD transfer with `in_last=1`:
  - if `wa` < 2^A−1, go to FILL;
  - if `wa` = 2^A−1, go directly to RUN.
- LOAD transfer with `in_last=0` at `wa` = 2^A−1: the word is written, then the state goes to ERR. A 2^A-word program must assert `in_last` on its final word.
- FILL: writes 0 (NOP) to addresses L … 2^A−1, where L is the number of words loaded, one address per cycle. The edge that issues address 2^A−1 moves the state to RUN.
- RUN: `cpu_rst_n`=1 and `done`=1. `reload`=1 moves the state to LOAD, clears `wa` and `words_loaded`, and drives `cpu_rst_n` to 0.
- ERR: `error`=1 and `cpu_rst_n` is held at 0. `reload` moves the state to LOAD and clears `error`.
- `reload` is ignored in LOAD and FILL.
- `words_loaded` saturates naturally at 2^A, because no transfers occur outside LOAD.
- Reset values: `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `cpu_rst_n`=0, `done`=0, `error`=0, `words_loaded`=0, state LOAD.
- Reset asserted mid-load aborts the load asynchronously. ROM contents already written are not cleared.

## Timing
- Write latency is 1 cycle. A transfer on edge e drives `rom_we`=1 with that address and data in the cycle after e. Back-to-back transfers produce back-to-back writes.
- A FILL write is driven in the cycle after each FILL-state edge.
- `rom_we` is 0 in any cycle that has no transfer or FILL write.
- `cpu_rst_n` rises (2^A − L + 1) cycles after the edge that transfers the last word.
- `cpu_rst_n` is 1 only while the ROM is stable. It is never 1 in a cycle where `rom_we`=1.
- `reload` in RUN: `cpu_rst_n`=0 and `in_ready`=1 from the next cycle onward.
- `error` rises in the cycle after the overflowing transfer, in the same cycle as that word's write.

## Structure
- Shared package `prog_loader_pkg` holds:
  - the state enum `loader_state_t` (LOAD, FILL, RUN, ERR);
  - the localparam for NOP encoding (0).
- A single module with no sub-module. `wa` and `words_loaded` are plain counters inside it.
- At system level, `cpu_rst_n` is ANDed with `rst_n` to form the processor's reset.

## Test plan
- Stream 2,3,4,5,6,7 back-to-back with `in_last` on the 7 (A=6) -> ROM[0..5]=2..7, ROM[6..63]=0, `cpu_rst_n` rises 59 cycles after the last transfer, `done`=1, `words_loaded`=6.
- Same stream with `in_valid` gapped every other cycle -> identical ROM contents; one write per transfer; no `rom_we` in gap cycles.
- 64 words 1..64 with `in_last` on the 64th -> no FILL, `cpu_rst_n`=1 one cycle after the last transfer, `words_loaded`=64.
- 64 words without `in_last` -> ROM[63] written, `error`=1, `cpu_rst_n` stays 0, `in_ready`=0. Then `reload` -> `error`=0, `in_ready`=1, `words_loaded`=0.
- After reaching RUN, pulse `reload` and load a 3-word program -> `cpu_rst_n` drops the next cycle, ROM[0..2] updated, ROM[3..63]=0, RUN re-entered after 62 cycles.
- Assert `rst_n`=0 during FILL -> all outputs take their reset values immediately; `reload` pulses in LOAD/FILL are ignored.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg : shared state type and NOP encoding for the program loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prog_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

  localparam int NOP_WORD = 0;

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader : streams a program into instruction ROM, zero-fills the tail,
//               then releases the processor from reset
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IW              = 12,
  parameter int ROM_addressBits = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [IW-1:0]              in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       reload,
  output logic                       rom_we,
  output logic [ROM_addressBits-1:0] rom_addr,
  output logic [IW-1:0]              rom_wdata,
  output logic                       cpu_rst_n,
  output logic                       done,
  output logic                       error,
  output logic [ROM_addressBits:0]   words_loaded
);

  localparam logic [ROM_addressBits-1:0] C_WA_MAX = '1;

  loader_state_t                state_q, state_d;
  logic [ROM_addressBits-1:0]   wa_q, wa_d;
  logic [ROM_addressBits:0]     words_q, words_d;
  logic                         rom_we_q, rom_we_d;
  logic [ROM_addressBits-1:0]   rom_addr_q, rom_addr_d;
  logic [IW-1:0]                rom_wdata_q, rom_wdata_d;
  logic                         cpu_rst_n_q, cpu_rst_n_d;

  always_comb begin
    state_d     = state_q;
    wa_d        = wa_q;
    words_d     = words_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_rst_n_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = wa_q;
          rom_wdata_d = in_data;
          wa_d        = wa_q + 1'b1;
          words_d     = words_q + 1'b1;
          if (in_last)
            state_d = (wa_q == C_WA_MAX) ? RUN : FILL;
          else if (wa_q == C_WA_MAX)
            state_d = ERR;
        end
      end
      FILL: begin
        rom_we_d    = 1'b1;
        rom_addr_d  = wa_q;
        rom_wdata_d = IW'(NOP_WORD);
        wa_d        = wa_q + 1'b1;
        if (wa_q == C_WA_MAX)
          state_d = RUN;
      end
      RUN, ERR: begin
        // Release only from a settled RUN, one cycle after the final ROM write
        if (reload) begin
          state_d = LOAD;
          wa_d    = '0;
          words_d = '0;
        end else begin
          cpu_rst_n_d = (state_q == RUN);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wa_q        <= '0;
      words_q     <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wa_q        <= wa_d;
      words_q     <= words_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign done         = (state_q == RUN);
  assign error        = (state_q == ERR);
  assign rom_we       = rom_we_q;
  assign rom_addr     = rom_addr_q;
  assign rom_wdata    = rom_wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader : directed self-checking bench for prog_loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        rom_we;
  logic [5:0]  rom_addr;
  logic [11:0] rom_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int overlap = 0;
  logic [11:0] rom_m [64];

  prog_loader #(.IW(12), .ROM_addressBits(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .reload(reload),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // ROM model captures writes mid-cycle
  always @(negedge clk) begin
    if (rst_n && rom_we) begin
      rom_m[rom_addr] = rom_wdata;
      wr_cnt = wr_cnt + 1;
      if (cpu_rst_n) overlap = overlap + 1;
    end
  end

  task automatic preset_model();
    for (int i = 0; i < 64; i++) rom_m[i] = 12'hAAA;
  endtask

  task automatic send(input logic [11:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (cpu_rst_n !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({rom_we, rom_addr, rom_wdata, cpu_rst_n, done, error} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%h cpu=%b done=%b err=%b, want all 0",
               rom_we, rom_addr, rom_wdata, cpu_rst_n, done, error);
    end
    checks++;
    if (words_loaded !== 7'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: words=%0d ready=%b, want 0 and 1", words_loaded, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n, base, ov, bad;
    preset_model();
    base = wr_cnt; ov = overlap;
    for (int i = 2; i <= 7; i++) send(12'(i), i == 7);
    wait_run(n);
    checks++;
    if (n !== 59) begin errors++; $display("FAIL b2b_release_delay: got %0d want 59", n); end
    checks++;
    if (done !== 1'b1 || words_loaded !== 7'd6) begin
      errors++; $display("FAIL b2b_done_words: done=%b words=%0d want 1 and 6", done, words_loaded);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rom_m[i] !== ((i < 6) ? 12'(i + 2) : 12'd0)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_rom: %0d bad locations want 0", bad); end
    checks++;
    if (wr_cnt - base !== 64 || overlap !== ov) begin
      errors++; $display("FAIL b2b_writes: writes=%0d overlap=%0d want 64 and %0d", wr_cnt - base, overlap, ov);
    end
  endtask

  task automatic test_reload_from_run();
    pulse_reload();
    checks++;
    if (cpu_rst_n !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || words_loaded !== 7'd0) begin
      errors++;
      $display("FAIL run_reload: cpu=%b ready=%b done=%b words=%0d want 0 1 0 0",
               cpu_rst_n, in_ready, done, words_loaded);
    end
  endtask

  task automatic test_gapped();
    int n, base, gapbad, bad;
    preset_model();
    base = wr_cnt; gapbad = 0;
    for (int i = 2; i <= 7; i++) begin
      send(12'(i), i == 7);
      if (i != 7) begin
        @(posedge clk); #1;
        if (rom_we) gapbad++;
      end
    end
    wait_run(n);
    checks++;
    if (gapbad !== 0) begin errors++; $display("FAIL gap_we: %0d gap writes want 0", gapbad); end
    checks++;
    if (n !== 59) begin errors++; $display("FAIL gap_release_delay: got %0d want 59", n); end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rom_m[i] !== ((i < 6) ? 12'(i + 2) : 12'd0)) bad++;
    checks++;
    if (bad !== 0 || wr_cnt - base !== 64) begin
      errors++; $display("FAIL gap_rom: bad=%0d writes=%0d want 0 and 64", bad, wr_cnt - base);
    end
  endtask

  task automatic test_overflow();
    pulse_reload();
    for (int i = 0; i < 64; i++) send(12'(i + 101), 1'b0);
    checks++;
    if (error !== 1'b1 || rom_we !== 1'b1 || rom_addr !== 6'd63) begin
      errors++; $display("FAIL ovf_edge: err=%b we=%b addr=%0d want 1 1 63", error, rom_we, rom_addr);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (cpu_rst_n !== 1'b0 || in_ready !== 1'b0 || error !== 1'b1 || rom_m[63] !== 12'd164) begin
      errors++;
      $display("FAIL ovf_hold: cpu=%b ready=%b err=%b rom63=%0d want 0 0 1 164",
               cpu_rst_n, in_ready, error, rom_m[63]);
    end
    pulse_reload();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1 || words_loaded !== 7'd0) begin
      errors++; $display("FAIL ovf_reload: err=%b ready=%b words=%0d want 0 1 0", error, in_ready, words_loaded);
    end
  endtask

  task automatic test_full();
    int n, bad;
    for (int i = 1; i <= 64; i++) send(12'(i), i == 64);
    wait_run(n);
    checks++;
    if (n !== 1 || words_loaded !== 7'd64 || done !== 1'b1) begin
      errors++; $display("FAIL full_run: delay=%0d words=%0d done=%b want 1 64 1", n, words_loaded, done);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (rom_m[i] !== 12'(i + 1)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_rom: %0d bad locations want 0", bad); end
  endtask

  task automatic test_three_word();
    int n, bad;
    pulse_reload();
    checks++;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL three_drop: cpu=%b want 0", cpu_rst_n); end
    send(12'h011, 1'b0); send(12'h022, 1'b0); send(12'h033, 1'b1);
    wait_run(n);
    checks++;
    if (n !== 62 || words_loaded !== 7'd3) begin
      errors++; $display("FAIL three_run: delay=%0d words=%0d want 62 3", n, words_loaded);
    end
    bad = 0;
    for (int i = 3; i < 64; i++) if (rom_m[i] !== 12'd0) bad++;
    checks++;
    if (rom_m[0] !== 12'h011 || rom_m[1] !== 12'h022 || rom_m[2] !== 12'h033 || bad !== 0) begin
      errors++; $display("FAIL three_rom: r0=%h r1=%h r2=%h tailbad=%0d want 011 022 033 0",
                         rom_m[0], rom_m[1], rom_m[2], bad);
    end
  endtask

  task automatic test_reset_in_fill();
    int n;
    pulse_reload();
    send(12'h005, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    pulse_reload();
    checks++;
    if (rom_we !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL fill_reload_ignored: we=%b ready=%b done=%b want 1 0 0", rom_we, in_ready, done);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rom_we, rom_addr, rom_wdata, cpu_rst_n, done, error} !== 22'd0 ||
        words_loaded !== 7'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: we=%b addr=%0d wdata=%h cpu=%b done=%b err=%b words=%0d ready=%b want reset values",
               rom_we, rom_addr, rom_wdata, cpu_rst_n, done, error, words_loaded, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(12'h021, 1'b0); send(12'h022, 1'b0);
    pulse_reload();
    checks++;
    if (in_ready !== 1'b1 || words_loaded !== 7'd2) begin
      errors++; $display("FAIL load_reload_ignored: ready=%b words=%0d want 1 2", in_ready, words_loaded);
    end
    send(12'h023, 1'b1);
    checks++;
    if (rom_we !== 1'b1 || rom_addr !== 6'd2 || rom_wdata !== 12'h023) begin
      errors++; $display("FAIL post_reset_write: we=%b addr=%0d data=%h want 1 2 023", rom_we, rom_addr, rom_wdata);
    end
    wait_run(n);
    checks++;
    if (n !== 62 || words_loaded !== 7'd3) begin
      errors++; $display("FAIL post_reset_run: delay=%0d words=%0d want 62 3", n, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reload_from_run();
    test_gapped();
    test_overflow();
    test_full();
    test_three_word();
    test_reset_in_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
